// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a per-register busy
// scoreboard for the dual-issue decode/writeback path.
//
// Ports:
//   clk, rst_n               clock (rising edge), async active-low reset
//   wr_en/wr_addr/wr_data    NWR writeback ports, packed per port
//   rd_en/rd_addr            NRD decode read ports, packed per port
//   rd_data/rd_busy          combinational read data and busy status
//   sb_set_en/sb_set_addr    mark a register busy (producer issued)
//   busy_vec                 raw registered scoreboard state
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*AW-1:0]     wr_addr,
    input  logic [NWR*XLEN-1:0]   wr_data,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  sb_set_en,
    input  logic [AW-1:0]         sb_set_addr,
    output logic [NREG-1:0]       busy_vec
);

    logic [NREG-1:0][XLEN-1:0] r_regs;
    logic [NREG-1:0]           r_busy;

    logic [NWR-1:0]            w_wr_ok;
    logic [NREG-1:0]           w_wr_hit;
    logic [NREG-1:0]           w_set_hit;
    logic [NREG-1:0][XLEN-1:0] w_wr_val;

    // Legal = inside the array and not the hard-wired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return (int'(a) < NREG) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    genvar k, j;
    generate
        for (k = 0; k < NWR; k++) begin : g_wr_ok
            assign w_wr_ok[k] = wr_en[k] && addr_ok(wr_addr[k*AW +: AW]);
        end
    endgenerate

    // Per-register write decode. Ports are scanned low to high so the
    // highest-index port writing a register wins.
    always_comb begin
        w_wr_hit  = '0;
        w_set_hit = '0;
        w_wr_val  = r_regs;
        for (int i = 0; i < NREG; i++) begin
            for (int p = 0; p < NWR; p++) begin
                if (w_wr_ok[p] && (wr_addr[p*AW +: AW] == AW'(i))) begin
                    w_wr_hit[i] = 1'b1;
                    w_wr_val[i] = wr_data[p*XLEN +: XLEN];
                end
            end
            w_set_hit[i] = sb_set_en && addr_ok(sb_set_addr) &&
                           (sb_set_addr == AW'(i));
        end
    end

    // Register 0 (when zeroed) is never a legal target, so it holds its
    // reset value of zero and never goes busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs <= '0;
            r_busy <= '0;
        end else begin
            r_regs <= w_wr_val;
            // A new producer issuing in the same cycle the old one retires
            // keeps the register busy.
            r_busy <= w_set_hit | (r_busy & ~w_wr_hit);
        end
    end

    assign busy_vec = r_busy;

    generate
        for (j = 0; j < NRD; j++) begin : g_rd
            logic [AW-1:0]   w_a;
            logic [XLEN-1:0] w_d;
            logic            w_b;

            assign w_a = rd_addr[j*AW +: AW];

            always_comb begin
                w_d = '0;
                w_b = 1'b0;
                if (rd_en[j] && addr_ok(w_a)) begin
                    w_d = r_regs[w_a];
                    w_b = r_busy[w_a];
                    // The read address is legal, so a matching write
                    // address is legal too; the forwarded value is not busy.
                    if (BYPASS != 0) begin
                        for (int p = 0; p < NWR; p++) begin
                            if (wr_en[p] && (wr_addr[p*AW +: AW] == w_a)) begin
                                w_d = wr_data[p*XLEN +: XLEN];
                                w_b = 1'b0;
                            end
                        end
                    end
                end
            end

            assign rd_data[j*XLEN +: XLEN] = w_d;
            assign rd_busy[j]              = w_b;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed checks of regfile_mp in three configurations:
//   u_a  default (BYPASS=1), u_b  BYPASS=0, u_c  NREG=24 NRD=3 NWR=1.
module tb_regfile_mp;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // default config
    logic [1:0]  a_wr_en;   logic [9:0]  a_wr_addr; logic [63:0] a_wr_data;
    logic [1:0]  a_rd_en;   logic [9:0]  a_rd_addr; logic [63:0] a_rd_data;
    logic [1:0]  a_rd_busy; logic        a_set;     logic [4:0]  a_set_addr;
    logic [31:0] a_busy_vec;
    // no-bypass config
    logic [1:0]  b_wr_en;   logic [9:0]  b_wr_addr; logic [63:0] b_wr_data;
    logic [1:0]  b_rd_en;   logic [9:0]  b_rd_addr; logic [63:0] b_rd_data;
    logic [1:0]  b_rd_busy; logic        b_set;     logic [4:0]  b_set_addr;
    logic [31:0] b_busy_vec;
    // non-power-of-two config
    logic [0:0]  c_wr_en;   logic [4:0]  c_wr_addr; logic [31:0] c_wr_data;
    logic [2:0]  c_rd_en;   logic [14:0] c_rd_addr; logic [95:0] c_rd_data;
    logic [2:0]  c_rd_busy; logic        c_set;     logic [4:0]  c_set_addr;
    logic [23:0] c_busy_vec;

    regfile_mp u_a (
        .clk(clk), .rst_n(rst_n),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .sb_set_en(a_set), .sb_set_addr(a_set_addr), .busy_vec(a_busy_vec)
    );

    regfile_mp #(.BYPASS(0)) u_b (
        .clk(clk), .rst_n(rst_n),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .sb_set_en(b_set), .sb_set_addr(b_set_addr), .busy_vec(b_busy_vec)
    );

    regfile_mp #(.NREG(24), .NRD(3), .NWR(1)) u_c (
        .clk(clk), .rst_n(rst_n),
        .wr_en(c_wr_en), .wr_addr(c_wr_addr), .wr_data(c_wr_data),
        .rd_en(c_rd_en), .rd_addr(c_rd_addr), .rd_data(c_rd_data), .rd_busy(c_rd_busy),
        .sb_set_en(c_set), .sb_set_addr(c_set_addr), .busy_vec(c_busy_vec)
    );

    task automatic idle();
        a_wr_en = '0; a_wr_addr = '0; a_wr_data = '0; a_rd_en = '0; a_rd_addr = '0;
        a_set = 1'b0; a_set_addr = '0;
        b_wr_en = '0; b_wr_addr = '0; b_wr_data = '0; b_rd_en = '0; b_rd_addr = '0;
        b_set = 1'b0; b_set_addr = '0;
        c_wr_en = '0; c_wr_addr = '0; c_wr_data = '0; c_rd_en = '0; c_rd_addr = '0;
        c_set = 1'b0; c_set_addr = '0;
    endtask

    task automatic test_reset();
        // write and set during reset must be lost
        a_wr_en = 2'b01; a_wr_addr[0 +: 5] = 5'd5; a_wr_data[0 +: 32] = 32'h1234;
        a_set = 1'b1; a_set_addr = 5'd5;
        @(posedge clk); #2;
        idle();
        a_rd_en = 2'b01; a_rd_addr[0 +: 5] = 5'd5;
        #1;
        n_cmp++;
        if (a_rd_data[0 +: 32] !== 32'h0) begin
            n_bad++; $display("FAIL reset_rd: got %h want %h", a_rd_data[0 +: 32], 32'h0);
        end
        n_cmp++;
        if (a_busy_vec !== 32'h0) begin
            n_bad++; $display("FAIL reset_busy_vec: got %h want %h", a_busy_vec, 32'h0);
        end
        n_cmp++;
        if (a_rd_busy !== 2'b00) begin
            n_bad++; $display("FAIL reset_rd_busy: got %b want %b", a_rd_busy, 2'b00);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_reg();
        @(negedge clk); idle();
        a_wr_en = 2'b01; a_wr_addr[0 +: 5] = 5'd0; a_wr_data[0 +: 32] = 32'hDEADBEEF;
        a_set = 1'b1; a_set_addr = 5'd0;
        a_rd_en = 2'b01; a_rd_addr[0 +: 5] = 5'd0;
        #2;
        n_cmp++;
        if (a_rd_data[0 +: 32] !== 32'h0) begin
            n_bad++; $display("FAIL zero_rd_same: got %h want %h", a_rd_data[0 +: 32], 32'h0);
        end
        n_cmp++;
        if (a_rd_busy[0] !== 1'b0) begin
            n_bad++; $display("FAIL zero_busy_same: got %b want %b", a_rd_busy[0], 1'b0);
        end
        @(negedge clk); idle();
        a_rd_en = 2'b01; a_rd_addr[0 +: 5] = 5'd0;
        #2;
        n_cmp++;
        if (a_rd_data[0 +: 32] !== 32'h0) begin
            n_bad++; $display("FAIL zero_rd_after: got %h want %h", a_rd_data[0 +: 32], 32'h0);
        end
        n_cmp++;
        if (a_busy_vec !== 32'h0) begin
            n_bad++; $display("FAIL zero_busy_vec: got %h want %h", a_busy_vec, 32'h0);
        end
    endtask

    task automatic test_dual_write();
        @(negedge clk); idle();
        a_wr_en = 2'b11;
        a_wr_addr[0 +: 5] = 5'd7; a_wr_data[0 +: 32]  = 32'h11111111;
        a_wr_addr[5 +: 5] = 5'd7; a_wr_data[32 +: 32] = 32'h22222222;
        a_rd_en = 2'b10; a_rd_addr[5 +: 5] = 5'd7;
        #2;
        n_cmp++;
        if (a_rd_data[32 +: 32] !== 32'h22222222) begin
            n_bad++; $display("FAIL dual_bypass: got %h want %h", a_rd_data[32 +: 32], 32'h22222222);
        end
        @(negedge clk); idle();
        a_rd_en = 2'b01; a_rd_addr[0 +: 5] = 5'd7;
        #2;
        n_cmp++;
        if (a_rd_data[0 +: 32] !== 32'h22222222) begin
            n_bad++; $display("FAIL dual_stored: got %h want %h", a_rd_data[0 +: 32], 32'h22222222);
        end
    endtask

    task automatic test_bypass();
        @(negedge clk); idle();
        a_wr_en = 2'b01; a_wr_addr[0 +: 5] = 5'd3; a_wr_data[0 +: 32] = 32'hA5A5A5A5;
        a_rd_en = 2'b01; a_rd_addr[0 +: 5] = 5'd3;
        b_wr_en = 2'b01; b_wr_addr[0 +: 5] = 5'd3; b_wr_data[0 +: 32] = 32'hA5A5A5A5;
        b_rd_en = 2'b01; b_rd_addr[0 +: 5] = 5'd3;
        #2;
        n_cmp++;
        if (a_rd_data[0 +: 32] !== 32'hA5A5A5A5) begin
            n_bad++; $display("FAIL bypass_on: got %h want %h", a_rd_data[0 +: 32], 32'hA5A5A5A5);
        end
        n_cmp++;
        if (b_rd_data[0 +: 32] !== 32'h0) begin
            n_bad++; $display("FAIL bypass_off_same: got %h want %h", b_rd_data[0 +: 32], 32'h0);
        end
        @(negedge clk); idle();
        a_rd_en = 2'b01; a_rd_addr[0 +: 5] = 5'd3;
        b_rd_en = 2'b01; b_rd_addr[0 +: 5] = 5'd3;
        #2;
        n_cmp++;
        if (b_rd_data[0 +: 32] !== 32'hA5A5A5A5) begin
            n_bad++; $display("FAIL bypass_off_next: got %h want %h", b_rd_data[0 +: 32], 32'hA5A5A5A5);
        end
        n_cmp++;
        if (a_rd_data[0 +: 32] !== 32'hA5A5A5A5) begin
            n_bad++; $display("FAIL bypass_on_next: got %h want %h", a_rd_data[0 +: 32], 32'hA5A5A5A5);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk); idle();
        a_set = 1'b1; a_set_addr = 5'd9;
        b_set = 1'b1; b_set_addr = 5'd9;
        @(negedge clk); idle();
        a_rd_en = 2'b10; a_rd_addr[5 +: 5] = 5'd9;
        b_rd_en = 2'b10; b_rd_addr[5 +: 5] = 5'd9;
        #2;
        n_cmp++;
        if (a_busy_vec[9] !== 1'b1) begin
            n_bad++; $display("FAIL sb_set_vec: got %b want %b", a_busy_vec[9], 1'b1);
        end
        n_cmp++;
        if (a_rd_busy[1] !== 1'b1) begin
            n_bad++; $display("FAIL sb_set_rd_busy: got %b want %b", a_rd_busy[1], 1'b1);
        end
        n_cmp++;
        if (b_rd_busy[1] !== 1'b1) begin
            n_bad++; $display("FAIL sb_set_rd_busy_nb: got %b want %b", b_rd_busy[1], 1'b1);
        end
        repeat (2) @(negedge clk);
        idle();
        a_wr_en = 2'b01; a_wr_addr[0 +: 5] = 5'd9; a_wr_data[0 +: 32] = 32'h55;
        b_wr_en = 2'b01; b_wr_addr[0 +: 5] = 5'd9; b_wr_data[0 +: 32] = 32'h55;
        a_rd_en = 2'b10; a_rd_addr[5 +: 5] = 5'd9;
        b_rd_en = 2'b10; b_rd_addr[5 +: 5] = 5'd9;
        #2;
        n_cmp++;
        if (a_rd_busy[1] !== 1'b0) begin
            n_bad++; $display("FAIL sb_wb_rd_busy: got %b want %b", a_rd_busy[1], 1'b0);
        end
        n_cmp++;
        if (a_rd_data[32 +: 32] !== 32'h55) begin
            n_bad++; $display("FAIL sb_wb_rd_data: got %h want %h", a_rd_data[32 +: 32], 32'h55);
        end
        n_cmp++;
        if (b_rd_busy[1] !== 1'b1) begin
            n_bad++; $display("FAIL sb_wb_rd_busy_nb: got %b want %b", b_rd_busy[1], 1'b1);
        end
        n_cmp++;
        if (b_rd_data[32 +: 32] !== 32'h0) begin
            n_bad++; $display("FAIL sb_wb_rd_data_nb: got %h want %h", b_rd_data[32 +: 32], 32'h0);
        end
        @(negedge clk); idle();
        b_rd_en = 2'b10; b_rd_addr[5 +: 5] = 5'd9;
        #2;
        n_cmp++;
        if (a_busy_vec[9] !== 1'b0) begin
            n_bad++; $display("FAIL sb_clr_vec: got %b want %b", a_busy_vec[9], 1'b0);
        end
        n_cmp++;
        if (b_busy_vec[9] !== 1'b0) begin
            n_bad++; $display("FAIL sb_clr_vec_nb: got %b want %b", b_busy_vec[9], 1'b0);
        end
        n_cmp++;
        if (b_rd_data[32 +: 32] !== 32'h55 || b_rd_busy[1] !== 1'b0) begin
            n_bad++; $display("FAIL sb_clr_rd_nb: got %h/%b want %h/%b",
                              b_rd_data[32 +: 32], b_rd_busy[1], 32'h55, 1'b0);
        end
    endtask

    task automatic test_collision();
        @(negedge clk); idle();
        a_set = 1'b1; a_set_addr = 5'd4;
        @(negedge clk); idle();
        a_set = 1'b1; a_set_addr = 5'd4;
        a_wr_en = 2'b10; a_wr_addr[5 +: 5] = 5'd4; a_wr_data[32 +: 32] = 32'h99;
        a_rd_en = 2'b01; a_rd_addr[0 +: 5] = 5'd4;
        #2;
        n_cmp++;
        if (a_rd_busy[0] !== 1'b0) begin
            n_bad++; $display("FAIL coll_fwd_busy: got %b want %b", a_rd_busy[0], 1'b0);
        end
        @(negedge clk); idle();
        a_rd_en = 2'b01; a_rd_addr[0 +: 5] = 5'd4;
        #2;
        n_cmp++;
        if (a_busy_vec[4] !== 1'b1) begin
            n_bad++; $display("FAIL coll_busy_vec: got %b want %b", a_busy_vec[4], 1'b1);
        end
        n_cmp++;
        if (a_rd_data[0 +: 32] !== 32'h99) begin
            n_bad++; $display("FAIL coll_data: got %h want %h", a_rd_data[0 +: 32], 32'h99);
        end
        n_cmp++;
        if (a_rd_busy[0] !== 1'b1) begin
            n_bad++; $display("FAIL coll_rd_busy: got %b want %b", a_rd_busy[0], 1'b1);
        end
    endtask

    task automatic test_npot();
        @(negedge clk); idle();
        c_wr_en = 1'b1; c_wr_addr = 5'd1; c_wr_data = 32'hAAAA0001;
        @(negedge clk); idle();
        c_wr_en = 1'b1; c_wr_addr = 5'd23; c_wr_data = 32'hBBBB0017;
        c_set = 1'b1; c_set_addr = 5'd23;
        @(negedge clk); idle();
        c_wr_en = 1'b1; c_wr_addr = 5'd30; c_wr_data = 32'hCCCC0030;
        c_set = 1'b1; c_set_addr = 5'd30;
        c_rd_en = 3'b111;
        c_rd_addr[0 +: 5] = 5'd30; c_rd_addr[5 +: 5] = 5'd1; c_rd_addr[10 +: 5] = 5'd23;
        #2;
        n_cmp++;
        if (c_rd_data[0 +: 32] !== 32'h0 || c_rd_busy[0] !== 1'b0) begin
            n_bad++; $display("FAIL npot_r30: got %h/%b want %h/%b",
                              c_rd_data[0 +: 32], c_rd_busy[0], 32'h0, 1'b0);
        end
        n_cmp++;
        if (c_rd_data[32 +: 32] !== 32'hAAAA0001 || c_rd_busy[1] !== 1'b0) begin
            n_bad++; $display("FAIL npot_r1: got %h/%b want %h/%b",
                              c_rd_data[32 +: 32], c_rd_busy[1], 32'hAAAA0001, 1'b0);
        end
        n_cmp++;
        if (c_rd_data[64 +: 32] !== 32'hBBBB0017 || c_rd_busy[2] !== 1'b1) begin
            n_bad++; $display("FAIL npot_r23: got %h/%b want %h/%b",
                              c_rd_data[64 +: 32], c_rd_busy[2], 32'hBBBB0017, 1'b1);
        end
        @(negedge clk); idle();
        c_rd_en = 3'b110;
        c_rd_addr[0 +: 5] = 5'd1; c_rd_addr[5 +: 5] = 5'd30; c_rd_addr[10 +: 5] = 5'd23;
        #2;
        n_cmp++;
        if (c_rd_data[0 +: 32] !== 32'h0) begin
            n_bad++; $display("FAIL npot_rd_dis: got %h want %h", c_rd_data[0 +: 32], 32'h0);
        end
        n_cmp++;
        if (c_rd_data[32 +: 32] !== 32'h0 || c_rd_busy[1] !== 1'b0) begin
            n_bad++; $display("FAIL npot_r30_after: got %h/%b want %h/%b",
                              c_rd_data[32 +: 32], c_rd_busy[1], 32'h0, 1'b0);
        end
        n_cmp++;
        if (c_busy_vec !== 24'h800000) begin
            n_bad++; $display("FAIL npot_busy_vec: got %h want %h", c_busy_vec, 24'h800000);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk); idle();
        a_wr_en = 2'b01; a_wr_addr[0 +: 5] = 5'd5; a_wr_data[0 +: 32] = 32'h1234;
        a_set = 1'b1; a_set_addr = 5'd5;
        @(negedge clk); idle();
        a_rd_en = 2'b01; a_rd_addr[0 +: 5] = 5'd5;
        #2;
        n_cmp++;
        if (a_rd_data[0 +: 32] !== 32'h1234 || a_rd_busy[0] !== 1'b1) begin
            n_bad++; $display("FAIL mid_pre: got %h/%b want %h/%b",
                              a_rd_data[0 +: 32], a_rd_busy[0], 32'h1234, 1'b1);
        end
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (a_rd_data[0 +: 32] !== 32'h0) begin
            n_bad++; $display("FAIL mid_rd: got %h want %h", a_rd_data[0 +: 32], 32'h0);
        end
        n_cmp++;
        if (a_busy_vec !== 32'h0 || b_busy_vec !== 32'h0 || c_busy_vec !== 24'h0) begin
            n_bad++; $display("FAIL mid_busy_vec: got %h/%h/%h want 0/0/0",
                              a_busy_vec, b_busy_vec, c_busy_vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_zero_reg();
        test_dual_write();
        test_bypass();
        test_scoreboard();
        test_collision();
        test_npot();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file with a per-register busy scoreboard, for the dual-issue decode/writeback path.
- Provides NRD combinational read ports to decode and NWR write ports from writeback.
- Optional same-cycle write-to-read bypass.
- Busy bit per register: set when decode issues a producer, cleared when writeback retires it; decode uses it for RAW stalls.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (>=2; need not be a power of two)
NRD, 2, number of read ports (>=1)
NWR, 2, number of write ports (>=1)
BYPASS, 1, 1 = a write in progress is forwarded to matching reads in the same cycle; 0 = reads see only stored state
ZERO_REG, 1, 1 = register 0 is hard-wired to zero and never busy
AW (localparam), $clog2(NREG), register address width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous, active-low reset
wr_en  input  NWR  per-port write enable (from wb)
wr_addr  input  NWR*AW  write addresses; port k occupies bits [k*AW +: AW]
wr_data  input  NWR*XLEN  write data, packed the same way
rd_en  input  NRD  per-port read enable (from de)
rd_addr  input  NRD*AW  read addresses, packed
rd_data  output  NRD*XLEN  read data (to de), combinational
rd_busy  output  NRD  busy status of each read address (to de), combinational
sb_set_en  input  1  mark a register busy (decode issued a producer)
sb_set_addr  input  AW  register to mark busy
busy_vec  output  NREG  raw scoreboard state, for debug and the stall unit

Behaviour:
- Reset (async, rst_n low): all registers = 0 and all busy bits = 0, effective immediately.
  - rd_data and rd_busy follow combinationally from the cleared state.
  - Any write or set that coincides with reset is lost.
- Write: on the rising edge, for each port k with wr_en[k]=1 and a legal address, the register takes wr_data[k].
  - An address is legal when it is < NREG and not 0 (the 0 exclusion applies only when ZERO_REG=1).
  - Illegal addresses are silently ignored.
  - Several ports writing the same address in one cycle: the highest-index port wins.
- Read port j, combinational, priority order:
  1. rd_en[j]=0 -> rd_data=0.
  2. Address illegal (>=NREG, or 0 with ZERO_REG=1) -> 0.
  3. BYPASS=1 and any enabled write port matches rd_addr[j] -> wr_data of the highest-index matching port.
  4. Otherwise -> stored register value.
  - With BYPASS=0 a read sees the new value one cycle after the write edge.
- Scoreboard:
  - A busy bit is set at the edge when sb_set_en=1 with a legal sb_set_addr.
  - A busy bit is cleared at the edge when any enabled write port targets that register.
  - Set and clear on the same register in the same cycle: set wins. A new producer has issued, so the register must stay busy.
  - Illegal set addresses are ignored; reg 0 is never busy when ZERO_REG=1.
- rd_busy[j]:
  - 0 when rd_en[j]=0 or the address is illegal.
  - Otherwise equals busy[addr].
  - BYPASS=1: forced to 0 when an enabled write port matches this cycle, since the value is being forwarded.
  - BYPASS=0: the write is not forwarded; the bit still reads 1 this cycle and drops after the edge.
- busy_vec reflects the registered state only, with no bypass masking.
- No internal state other than the register array and the busy bits; there is no read latency.

Test Plan:
- Reset and zero register: write 0xDEADBEEF to r0 via port 0, read r0 -> rd_data=0 and rd_busy=0. Pulse rst_n mid-run after writing r5=0x1234 -> r5 reads 0 and busy_vec=0.
- Dual write conflict: same cycle, port0 writes r7=0x11111111 and port1 writes r7=0x22222222 -> next cycle r7 reads 0x22222222. With BYPASS=1, a read of r7 in the write cycle also returns 0x22222222.
- Bypass versus no bypass: write r3=0xA5A5A5A5 and read r3 in the same cycle.
  - BYPASS=1 -> rd_data=0xA5A5A5A5 immediately.
  - BYPASS=0 -> old value (0) this cycle, 0xA5A5A5A5 the next.
- Scoreboard lifecycle: set r9 -> busy_vec[9]=1 and rd_busy=1 on a read of r9. Three cycles later wb writes r9=0x55 -> with BYPASS=1, rd_busy=0 in that cycle and busy_vec[9]=0 after the edge.
- Set/clear collision: r4 busy; in the same cycle sb_set_addr=4 and wb writes r4=0x99 -> after the edge busy_vec[4]=1 and r4=0x99.
- Non-power-of-two config (NREG=24, NRD=3, NWR=1): write and set to r30 are ignored. Reads of r30 -> 0 with rd_busy=0, while the other two ports read r1 and r23 correctly.
